// File: rtl/count_uart_pkg.sv
// rtl/count_uart_pkg.sv - shared state encoding and frame constants; COUNT_UART_PARITY_EN adds the parity bit
package count_uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  function automatic int unsigned frame_bits();
`ifdef COUNT_UART_PARITY_EN
    return 11;
`else
    return 10;
`endif
  endfunction

endpackage

// File: rtl/count_uart_if.sv
// rtl/count_uart_if.sv - valid/ready byte handshake into the UART transmitter
interface count_uart_if;
  import count_uart_pkg::*;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);

endinterface

// File: rtl/count_baud_gen.sv
// rtl/count_baud_gen.sv - bit-period divider; tick marks the last cycle of each bit
module count_baud_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick,
  output logic tick_next
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PREV = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // tick_next lets the owner register a flag that lines up with tick
  assign tick      = run && (cnt == LAST);
  assign tick_next = run && (cnt == PREV);

endmodule

// File: rtl/count_uart_tx.sv
// rtl/count_uart_tx.sv - 8N1 serialiser for the counter byte; COUNT_UART_PARITY_EN inserts an even-parity bit
module count_uart_tx
  import count_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  count_uart_if.slave in_if,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
    $error("count_uart_tx: CLKS_PER_BIT must be within 2..65535");
  end
  if (DATA_W != 8) begin : g_bad_width
    $error("count_uart_tx: DATA_W must be 8");
  end

  localparam logic [2:0] IDLE   = S_IDLE;
  localparam logic [2:0] START  = S_START;
  localparam logic [2:0] DATA   = S_DATA;
  localparam logic [2:0] STOP   = S_STOP;
`ifdef COUNT_UART_PARITY_EN
  localparam logic [2:0] PARITY = S_PARITY;
`endif

  logic [2:0]        state;
  logic [DATA_W-1:0] shift;
  logic [2:0]        bit_idx;
  logic              in_ready_q;
  logic              tick;
  logic              tick_next;
  logic              run;

  assign run          = (state != IDLE);
  assign in_if.in_ready = in_ready_q;

  count_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .tick     (tick),
    .tick_next(tick_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      bit_idx    <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      done <= (state == STOP) && tick_next;
      case (state)
        IDLE: begin
          if (in_if.in_valid && in_ready_q) begin
            shift      <= in_if.in_data;
            state      <= START;
            tx         <= 1'b0;
            busy       <= 1'b1;
            in_ready_q <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            bit_idx <= 3'd0;
            tx      <= shift[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
`ifdef COUNT_UART_PARITY_EN
              state <= PARITY;
              tx    <= ^shift;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[bit_idx + 3'd1];
            end
          end
        end
`ifdef COUNT_UART_PARITY_EN
        PARITY: begin
          if (tick) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            state      <= IDLE;
            bit_idx    <= 3'd0;
            busy       <= 1'b0;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          tx         <= 1'b1;
          busy       <= 1'b0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_uart_tx.sv
// tb/tb_count_uart_tx.sv - self-checking bench for count_uart_tx (build with COUNT_UART_PARITY_EN for the parity frame)
module tb_count_uart_tx;

  localparam int CPB = 4;
`ifdef COUNT_UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       par;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic tx;
  logic busy;
  logic done;

  count_uart_if uif ();

  count_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .in_if(uif),
    .tx   (tx),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   pushed = 0;
  int   aborted = 0;
  int   frames_seen = 0;
  vec_t exp_q[$];
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic exp_bit(input vec_t v, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return v.data[b-1];
    if (FB == 11 && b == 9) return v.par;
    return 1'b1;
  endfunction

  task automatic send(input vec_t v);
    int n;
    n = 0;
    @(negedge clk);
    uif.in_data  = v.data;
    uif.in_valid = 1'b1;
    while (uif.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready_timeout", 32'(n < 200), 32'd1);
    @(posedge clk);
    exp_q.push_back(v);
    pushed++;
    @(negedge clk);
    uif.in_valid = 1'b0;
    uif.in_data  = ~v.data;
  endtask

  // Entered on the falling edge of the first cycle after acceptance.
  task automatic check_frame(input vec_t v, input int inject_at, input int rst_at);
    int b;
    for (int c = 1; c <= FB * CPB; c++) begin
      b = (c - 1) / CPB;
      chk("tx_bit", 32'(tx), 32'(exp_bit(v, b)));
      chk("busy_frame", 32'(busy), 32'd1);
      chk("in_ready_frame", 32'(uif.in_ready), 32'd0);
      chk("done_pos", 32'(done), 32'(c == FB * CPB));
      if (c == inject_at) begin
        uif.in_valid = 1'b1;
        uif.in_data  = 8'h33;
      end
      if (c == inject_at + 1) uif.in_valid = 1'b0;
      if (c == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    chk("post_tx", 32'(tx), 32'd1);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_in_ready", 32'(uif.in_ready), 32'd1);
    chk("post_done", 32'(done), 32'd0);
  endtask

  // Line decoder: samples mid-bit, compares against the scoreboard.
  initial begin : monitor
    logic [7:0] got;
    logic       st;
    logic       sb;
    bit         abort;
    vec_t       e;
`ifdef COUNT_UART_PARITY_EN
    logic       pb;
    pb = 1'b0;
`endif
    got = '0;
    st  = 1'b1;
    sb  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        abort = 1'b0;
        for (int c = 0; c < CPB / 2; c++) begin
          @(negedge clk);
          if (rst) abort = 1'b1;
        end
        st = tx;
        for (int b = 0; b < FB - 1; b++) begin
          if (!abort) begin
            for (int c = 0; c < CPB; c++) begin
              @(negedge clk);
              if (rst) abort = 1'b1;
            end
            if (b < 8) got[b] = tx;
            else if (b < FB - 2) begin
`ifdef COUNT_UART_PARITY_EN
              pb = tx;
`endif
            end
            else sb = tx;
          end
        end
        if (!abort) begin
          frames_seen++;
          chk("mon_start_bit", 32'(st), 32'd0);
          chk("mon_stop_bit", 32'(sb), 32'd1);
          if (exp_q.size() == 0) begin
            chk("mon_unexpected_frame", {24'd0, got}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("mon_data", {24'd0, got}, {24'd0, e.data});
`ifdef COUNT_UART_PARITY_EN
            chk("mon_parity", 32'(pb), 32'(e.par));
`endif
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    vecs[0] = '{data: 8'hA5, par: 1'b0};
    vecs[1] = '{data: 8'h00, par: 1'b0};
    vecs[2] = '{data: 8'hFF, par: 1'b0};
    vecs[3] = '{data: 8'h5A, par: 1'b0};
    vecs[4] = '{data: 8'h80, par: 1'b1};
    vecs[5] = '{data: 8'h01, par: 1'b1};
    vecs[6] = '{data: 8'h07, par: 1'b1};
    vecs[7] = '{data: 8'h03, par: 1'b0};

    rst          = 1'b1;
    uif.in_valid = 1'b1;
    uif.in_data  = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_in_ready", 32'(uif.in_ready), 32'd1);
    end
    rst          = 1'b0;
    uif.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("idle_tx", 32'(tx), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    for (int i = 0; i < 8; i++) begin
      send(vecs[i]);
      check_frame(vecs[i], 0, 0);
    end

    // Back-to-back with in_valid held: 0x00 then 0xFF.
    @(negedge clk);
    uif.in_data  = 8'h00;
    uif.in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back('{data: 8'h00, par: 1'b0});
    pushed++;
    @(negedge clk);
    uif.in_data = 8'hFF;
    for (int c = 1; c <= FB * CPB; c++) begin
      chk("b2b_done", 32'(done), 32'(c == FB * CPB));
      @(negedge clk);
    end
    chk("b2b_gap_tx", 32'(tx), 32'd1);
    chk("b2b_gap_ready", 32'(uif.in_ready), 32'd1);
    @(posedge clk);
    exp_q.push_back('{data: 8'hFF, par: 1'b0});
    pushed++;
    @(negedge clk);
    chk("b2b_second_start", 32'(tx), 32'd0);
    chk("b2b_second_busy", 32'(busy), 32'd1);
    uif.in_valid = 1'b0;
    repeat (FB * CPB) @(negedge clk);
    chk("b2b_end_busy", 32'(busy), 32'd0);

    // in_valid pulse during DATA must be dropped.
    send('{data: 8'h11, par: 1'b0});
    check_frame('{data: 8'h11, par: 1'b0}, 12, 0);
    for (int c = 0; c < 3 * CPB; c++) begin
      chk("reject_no_frame", 32'(busy), 32'd0);
      @(negedge clk);
    end

    // Reset during data bit 3 abandons the frame.
    send('{data: 8'hC3, par: 1'b0});
    check_frame('{data: 8'hC3, par: 1'b0}, 0, 18);
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_in_ready", 32'(uif.in_ready), 32'd1);
    exp_q.delete();
    aborted++;
    rst = 1'b0;
    for (int c = 0; c < 2 * CPB; c++) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(done), 32'd0);
    end
    send('{data: 8'h01, par: 1'b1});
    check_frame('{data: 8'h01, par: 1'b1}, 0, 0);

    repeat (2 * CPB) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("frame_count", 32'(frames_seen), 32'(pushed - aborted));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_uart_tx.md
Name: count_uart_tx

Overview:
- Downstream consumer of the 8-bit counter value. Serialises each accepted byte onto a single UART TX line as 8N1: start bit, 8 data bits LSB first, stop bit.
- Lets the counter state be observed off-chip over one dedicated output pin instead of the 8-bit bidirectional bus.
- Simple valid/ready input handshake. Baud timing is derived from the system clock by an integer divider.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per UART bit. Legal range 2..65535; elaboration error outside that range.
- DATA_W, 8, payload width. Fixed at 8; any other value is an elaboration error.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_data  input  8  byte to transmit, typically the counter value.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a byte this cycle.
- tx  output  1  UART serial line; idles high.
- busy  output  1  frame in progress (any state other than IDLE).
- done  output  1  single-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst: synchronous, active-high.
- Registered outputs: all outputs come from registers.
- Values while rst=1 and after it releases: tx=1, busy=0, done=0, in_ready=1, state=IDLE, baud counter=0, bit index=0.
- States: IDLE -> START -> DATA -> STOP -> IDLE. With COUNT_UART_PARITY_EN the path is DATA -> PARITY -> STOP.
- Accept: a transfer happens at a rising edge where in_valid=1 and in_ready=1.
  - in_data is latched into a shift register at that edge.
  - After the same edge: state=START, tx=0, in_ready=0, busy=1.
  - in_data changes after acceptance are ignored.
- Bit timing: every bit (start, data, parity, stop) holds tx for exactly CLKS_PER_BIT cycles.
  - Baud counter counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
  - Bit advance occurs on the edge where the counter equals CLKS_PER_BIT-1; the counter then wraps to 0.
- DATA: 3-bit index runs 0..7; tx = shift[index], LSB first. Leaves DATA after index 7 has completed its full bit period.
- STOP: tx=1. done=1 during the last cycle of the stop bit only.
- End of frame: on the edge following that last cycle, state=IDLE, busy=0, in_ready=1, done=0.
- Frame length: 10*CLKS_PER_BIT cycles from acceptance edge to IDLE, or 11*CLKS_PER_BIT with parity.
- Minimum line-idle between back-to-back frames: stop bit plus 1 cycle.
- in_valid while busy: ignored; no byte accepted or queued. Upstream must hold in_valid until it sees in_ready.
- Reset mid-frame: at the rst edge the frame is abandoned, tx=1, and no done pulse is produced.
- rst and in_valid together: rst wins; nothing is accepted.

Optional Feature:
- COUNT_UART_PARITY_EN defined:
  - An even-parity bit (XOR of the 8 latched data bits) is sent in PARITY state between DATA and STOP.
  - Frame becomes 11 bits.
- Not defined: no PARITY state, 10-bit frame, parity logic absent from netlist.

Decomposition:
- Package count_uart_pkg holds:
  - State enum: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; 3-bit encoding.
  - Localparam DATA_W=8.
  - Function computing frame bit count from the macro.
- Sub-module count_baud_gen: parameter CLKS_PER_BIT; inputs clk, rst, run; output tick.
  - tick pulses on the last cycle of each bit period.
  - The counter clears whenever run=0.

Test Plan:
- Reset: hold rst=1 for 3 cycles with in_valid=1, in_data=0x5A -> tx=1, busy=0, done=0, in_ready=1 throughout; nothing transmitted.
- Single byte, CLKS_PER_BIT=4, send 0xA5:
  - tx per 4-cycle bit = 0,1,0,1,0,0,1,0,1,1.
  - done high exactly once, at cycle 40 after acceptance.
  - in_ready returns 1 one cycle later.
- Back-to-back 0x00 then 0xFF with in_valid held high -> second start bit begins 2 cycles after the done pulse; the second frame decodes to 0xFF.
- Busy rejection: pulse in_valid with 0x33 during the DATA bits of 0x11 -> only 0x11 is framed; no second frame.
- Reset mid-frame: assert rst at data bit 3 of 0xC3 -> tx=1 on the next edge, no done pulse, next byte 0x01 framed correctly.
- COUNT_UART_PARITY_EN: send 0x07 -> parity bit 1 before stop; send 0x03 -> parity bit 0; frame = 44 cycles at CLKS_PER_BIT=4.
